// File: rtl/rv32i_if_fetch_buf_if.sv
// Fetch-buffer bus: fetch push side, decode head side, flush and occupancy.
interface rv32i_if_fetch_buf_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             i_fetch_valid;
    logic [WIDTH-1:0] i_fetch_pc;
    logic [WIDTH-1:0] i_fetch_pc_plus_4;
    logic [WIDTH-1:0] i_fetch_instr;
    logic             o_fetch_ready;
    logic             o_id_valid;
    logic [WIDTH-1:0] o_id_pc;
    logic [WIDTH-1:0] o_id_pc_plus_4;
    logic [WIDTH-1:0] o_id_instr;
    logic             i_id_stall;
    logic             i_flush;
    logic [CNT_W-1:0] o_count;

    // Driver of fetch/decode controls (pipeline side)
    modport master (
        output i_fetch_valid, i_fetch_pc, i_fetch_pc_plus_4, i_fetch_instr,
        output i_id_stall, i_flush,
        input  o_fetch_ready, o_id_valid, o_id_pc, o_id_pc_plus_4, o_id_instr, o_count
    );

    // The buffer itself
    modport slave (
        input  i_fetch_valid, i_fetch_pc, i_fetch_pc_plus_4, i_fetch_instr,
        input  i_id_stall, i_flush,
        output o_fetch_ready, o_id_valid, o_id_pc, o_id_pc_plus_4, o_id_instr, o_count
    );
endinterface

// File: rtl/rv32i_if_fetch_buf.sv
// IF->ID instruction buffer: DEPTH-entry FIFO of {pc, pc+4, instr} with stall and flush.
module rv32i_if_fetch_buf #(
    parameter int unsigned     WIDTH     = 32,
    parameter int unsigned     DEPTH     = 2,
    parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(32'h0000_0013)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rv32i_if_fetch_buf_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] pc_mem_q    [DEPTH];
    logic [WIDTH-1:0] ppc_mem_q   [DEPTH];
    logic [WIDTH-1:0] instr_mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic ready_c;
    logic valid_c;
    logic push_c;
    logic pop_c;

    // Handshake terms; ready and valid depend on registered occupancy only
    assign ready_c = (count_q != CNT_W'(DEPTH));
    assign valid_c = (count_q != CNT_W'(0));
    assign push_c  = bus.i_fetch_valid & ready_c & ~bus.i_flush;
    assign pop_c   = valid_c & ~bus.i_id_stall & ~bus.i_flush;

    // Head presentation; empty buffer shows a NOP with zero pcs
    assign bus.o_fetch_ready  = ready_c;
    assign bus.o_id_valid     = valid_c;
    assign bus.o_count        = count_q;
    assign bus.o_id_pc        = valid_c ? pc_mem_q[rd_ptr_q]    : '0;
    assign bus.o_id_pc_plus_4 = valid_c ? ppc_mem_q[rd_ptr_q]   : '0;
    assign bus.o_id_instr     = valid_c ? instr_mem_q[rd_ptr_q] : NOP_INSTR;

    // Next pointers and occupancy; flush clears everything and drops push/pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; not reset, hidden by the valid gating on the head
    always_ff @(posedge clk) begin
        if (push_c) begin
            pc_mem_q[wr_ptr_q]    <= bus.i_fetch_pc;
            ppc_mem_q[wr_ptr_q]   <= bus.i_fetch_pc_plus_4;
            instr_mem_q[wr_ptr_q] <= bus.i_fetch_instr;
        end
    end
endmodule
